// File: rtl/steering_pkg.sv
// Shared types for the line-sensor front end: scan FSM states and the sensor vector.
// Pure declarations; no latency or flow control.
package steering_pkg;
  localparam int NUM_SENSORS_DEF = 5;
  localparam int SEL_W           = 3;

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, EVAL} scan_state_t;
  typedef logic [NUM_SENSORS_DEF-1:0] sensor_vec_t;
endpackage

// File: rtl/frame_debouncer.sv
// Whole-frame debouncer: publishes a frame after DEBOUNCE identical evals, s_valid one cycle after the eval edge.
// No backpressure; SCAN_GLITCH_CNT_EN adds a saturating count of candidates rejected before stabilising.
module frame_debouncer #(
  parameter int N        = 5,
  parameter int DEBOUNCE = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         eval,
  input  logic         clear,
  input  logic [N-1:0] frame,
  output logic [N-1:0] s,
  output logic         s_valid
`ifdef SCAN_GLITCH_CNT_EN
  ,
  output logic [7:0]   glitch_cnt
`endif
);
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE);

  logic [N-1:0]  candidate;
  logic [N-1:0]  cand_nxt;
  logic [CW-1:0] stable_cnt;
  logic [CW-1:0] cnt_nxt;
  logic          mismatch;
  logic          publish;

  always_comb begin
    mismatch = (frame != candidate);
    cand_nxt = candidate;
    cnt_nxt  = stable_cnt;
    if (mismatch) begin
      cand_nxt = frame;
      cnt_nxt  = CW'(1);
    end else if (stable_cnt != CNT_MAX) begin
      cnt_nxt = stable_cnt + CW'(1);
    end
    // Only a value that differs from what is already published produces a strobe.
    publish = eval && (cnt_nxt == CNT_MAX) && (cand_nxt != s);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      candidate  <= '0;
      stable_cnt <= '0;
      s          <= '0;
      s_valid    <= 1'b0;
    end else begin
      s_valid <= publish;
      if (clear) begin
        stable_cnt <= '0;
      end else if (eval) begin
        candidate  <= cand_nxt;
        stable_cnt <= cnt_nxt;
        if (publish) s <= cand_nxt;
      end
    end
  end

`ifdef SCAN_GLITCH_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      glitch_cnt <= '0;
    end else if (eval && mismatch && (stable_cnt != '0) && (stable_cnt < CNT_MAX)
                 && (glitch_cnt != 8'hFF)) begin
      glitch_cnt <= glitch_cnt + 8'd1;
    end
  end
`endif
endmodule

// File: rtl/sensor_scanner.sv
// Scans NUM_SENSORS comparators through one analog mux (settle, then sample) and debounces whole frames.
// Scan period NUM_SENSORS*(SETTLE_CYCLES+1)+1 cycles; no backpressure; SCAN_GLITCH_CNT_EN adds glitch_cnt.
module sensor_scanner
  import steering_pkg::*;
#(
  parameter int NUM_SENSORS   = NUM_SENSORS_DEF,
  parameter int SETTLE_CYCLES = 4,
  parameter int DEBOUNCE      = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   sense_in,
  output logic [SEL_W-1:0]       sel,
  output logic [NUM_SENSORS-1:0] s,
  output logic                   s_valid
`ifdef SCAN_GLITCH_CNT_EN
  ,
  output logic [7:0]             glitch_cnt
`endif
);
  localparam int SCW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SCW-1:0]   SETTLE_LAST = SCW'(SETTLE_CYCLES - 1);
  localparam logic [SEL_W-1:0] IDX_LAST    = SEL_W'(NUM_SENSORS - 1);

  scan_state_t            state, state_nxt;
  logic [SEL_W-1:0]       idx, idx_nxt;
  logic [SCW-1:0]         settle_cnt, settle_nxt;
  logic [NUM_SENSORS-1:0] frame, frame_nxt;
  logic                   eval;
  logic                   abort;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    settle_nxt = settle_cnt;
    frame_nxt  = frame;
    sel        = '0;
    eval       = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_nxt  = SETTLE;
          idx_nxt    = '0;
          settle_nxt = '0;
        end
      end
      SETTLE: begin
        sel = idx;
        if (!enable) begin
          state_nxt  = IDLE;
          abort      = 1'b1;
          idx_nxt    = '0;
          settle_nxt = '0;
        end else if (settle_cnt == SETTLE_LAST) begin
          state_nxt  = SAMPLE;
          settle_nxt = '0;
        end else begin
          settle_nxt = settle_cnt + SCW'(1);
        end
      end
      SAMPLE: begin
        sel = idx;
        if (!enable) begin
          // Partial frame is dropped: the bit of this slot is not captured.
          state_nxt = IDLE;
          abort     = 1'b1;
          idx_nxt   = '0;
        end else begin
          for (int i = 0; i < NUM_SENSORS; i++) begin
            if (idx == SEL_W'(i)) frame_nxt[i] = sense_in;
          end
          if (idx == IDX_LAST) begin
            state_nxt = EVAL;
          end else begin
            idx_nxt   = idx + SEL_W'(1);
            state_nxt = SETTLE;
          end
        end
      end
      EVAL: begin
        eval       = 1'b1;
        idx_nxt    = '0;
        settle_nxt = '0;
        state_nxt  = enable ? SETTLE : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx        <= '0;
      settle_cnt <= '0;
      frame      <= '0;
    end else begin
      idx        <= idx_nxt;
      settle_cnt <= settle_nxt;
      frame      <= frame_nxt;
    end
  end

  frame_debouncer #(
    .N        (NUM_SENSORS),
    .DEBOUNCE (DEBOUNCE)
  ) u_debouncer (
    .clk        (clk),
    .reset_n    (reset_n),
    .eval       (eval),
    .clear      (abort),
    .frame      (frame),
    .s          (s),
    .s_valid    (s_valid)
`ifdef SCAN_GLITCH_CNT_EN
    ,
    .glitch_cnt (glitch_cnt)
`endif
  );
endmodule
